wb_initiator: RTL and testbench

WB_INITIATOR -- requirements
Module: wb_initiator

---
 rtl/wb_initiator_if.sv | 54 +++++
 rtl/wb_initiator.sv | 141 ++++++++++++++
 tb/tb_wb_initiator.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_initiator_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_initiator_if
//  Description : Bundles the request/response handshake and the Wishbone
//                classic master signals of wb_initiator.
//                The master modport is the initiator's view.
//                The slave modport is the view of the requester and the
//                Wishbone slave.
//  Signals     : req_*  command channel (valid/ready, we, adr, dat, sel)
//                rsp_*  response channel (valid/ready, dat, timeout)
//                wbm_*  Wishbone classic master port
//  Revision    : 1.0  initial release
// ============================================================================
interface wb_initiator_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_adr;
   logic [31:0] req_dat;
   logic [3:0]  req_sel;

   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_dat;
   logic        rsp_timeout;

   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic        wbm_we_o;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_dat_i;
   logic        wbm_ack_i;

   modport master (
      input  req_valid, req_we, req_adr, req_dat, req_sel,
      input  rsp_ready,
      input  wbm_dat_i, wbm_ack_i,
      output req_ready,
      output rsp_valid, rsp_dat, rsp_timeout,
      output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
   );

   modport slave (
      output req_valid, req_we, req_adr, req_dat, req_sel,
      output rsp_ready,
      output wbm_dat_i, wbm_ack_i,
      input  req_ready,
      input  rsp_valid, rsp_dat, rsp_timeout,
      input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
   );
endinterface
`default_nettype wire

// File: rtl/wb_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : wb_initiator
//  Description : Single-outstanding Wishbone classic master.
//                It accepts one command in IDLE and runs it on the bus in BUS.
//                It then presents the result in RESP until the response is
//                consumed.
//                A bus cycle that gets no ack within TIMEOUT_CYCLES strobe
//                cycles ends with rsp_timeout=1.
//  Ports       : wb_clk_i  clock, rising edge
//                wb_rst_i  synchronous active-high reset
//                bus       wb_initiator_if.master (request, response, Wishbone)
//                busy      high whenever the FSM is not in IDLE
//  Revision    : 1.0  initial release
// ============================================================================
module wb_initiator #(
   parameter int unsigned TIMEOUT_CYCLES = 16   // 1..255
) (
   input  wire logic             wb_clk_i,
   input  wire logic             wb_rst_i,
   wb_initiator_if.master        bus,
   output      logic             busy
);

   localparam logic [1:0] c_st_idle = 2'd0;
   localparam logic [1:0] c_st_bus  = 2'd1;
   localparam logic [1:0] c_st_resp = 2'd2;

   // The final strobe cycle is the one where the timer has reached this value.
   localparam logic [7:0] c_timeout_last = 8'(TIMEOUT_CYCLES - 1);

   logic [1:0]  r_state;
   logic [1:0]  w_next_state;

   logic        r_we;
   logic [31:0] r_adr;
   logic [31:0] r_dat;
   logic [3:0]  r_sel;
   logic [31:0] r_rsp_dat;
   logic        r_rsp_timeout;
   logic [7:0]  r_timer;

   logic        w_req_ready;
   logic        w_cyc;
   logic        w_rsp_valid;
   logic        w_busy;
   logic        w_timer_last;

   assign w_timer_last = (r_timer == c_timeout_last);

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_next_state;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_st_idle: if (bus.req_valid)                 w_next_state = c_st_bus;
         // An ack on the final timeout cycle still lands in RESP.
         // The datapath below makes the ack win over the timeout.
         c_st_bus:  if (bus.wbm_ack_i || w_timer_last) w_next_state = c_st_resp;
         c_st_resp: if (bus.rsp_ready)                 w_next_state = c_st_idle;
         default:                                      w_next_state = c_st_idle;
      endcase
   end

   // ------------------------------------------------- outputs decoded from state
   always_comb begin
      w_req_ready = 1'b0;
      w_cyc       = 1'b0;
      w_rsp_valid = 1'b0;
      w_busy      = 1'b1;
      case (r_state)
         c_st_idle: begin
            w_req_ready = 1'b1;
            w_busy      = 1'b0;
         end
         c_st_bus:  w_cyc       = 1'b1;
         c_st_resp: w_rsp_valid = 1'b1;
         default:   w_busy      = 1'b0;
      endcase
   end

   // ----------------------------------------------------------------- datapath
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_we          <= 1'b0;
         r_adr         <= 32'h0;
         r_dat         <= 32'h0;
         r_sel         <= 4'h0;
         r_rsp_dat     <= 32'h0;
         r_rsp_timeout <= 1'b0;
         r_timer       <= 8'h0;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (bus.req_valid) begin
                  r_we    <= bus.req_we;
                  r_adr   <= bus.req_adr;
                  r_dat   <= bus.req_dat;
                  r_sel   <= bus.req_sel;
                  r_timer <= 8'h0;
               end
            end
            c_st_bus: begin
               if (bus.wbm_ack_i) begin
                  // Read data is sampled only on the ack edge of a read.
                  r_rsp_dat     <= r_we ? 32'h0 : bus.wbm_dat_i;
                  r_rsp_timeout <= 1'b0;
               end else if (w_timer_last) begin
                  r_rsp_dat     <= 32'h0;
                  r_rsp_timeout <= 1'b1;
               end else begin
                  r_timer <= r_timer + 8'd1;
               end
            end
            default: ;  // RESP holds everything; stray acks have no effect
         endcase
      end
   end

   assign bus.req_ready   = w_req_ready;
   assign bus.rsp_valid   = w_rsp_valid;
   assign bus.rsp_dat     = r_rsp_dat;
   assign bus.rsp_timeout = r_rsp_timeout;
   assign bus.wbm_cyc_o   = w_cyc;
   assign bus.wbm_stb_o   = w_cyc;
   assign bus.wbm_we_o    = r_we;
   assign bus.wbm_adr_o   = r_adr;
   assign bus.wbm_dat_o   = r_dat;
   assign bus.wbm_sel_o   = r_sel;
   assign busy            = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_wb_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_initiator
//  Description : Directed self-checking bench for wb_initiator.
//                It covers read, write, timeout, ack on the final timeout
//                cycle, response backpressure and reset during BUS.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_wb_initiator;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy;

   int n_checks = 0;
   int n_pass   = 0;

   wb_initiator_if bus ();

   wb_initiator #(
      .TIMEOUT_CYCLES (16)
   ) u_dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .bus      (bus.master),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   // Inputs are driven and outputs sampled 1 ns after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_adr   = adr;
      bus.req_dat   = dat;
      bus.req_sel   = sel;
      tick();
      bus.req_valid = 1'b0;
   endtask

   task automatic consume();
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      check("rsp_valid_after_consume", {31'b0, bus.rsp_valid}, 32'd0);
      check("req_ready_after_consume", {31'b0, bus.req_ready}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_adr   = 32'h0;
      bus.req_dat   = 32'h0;
      bus.req_sel   = 4'h0;
      bus.rsp_ready = 1'b0;
      bus.wbm_dat_i = 32'h0;
      bus.wbm_ack_i = 1'b0;

      // ---------------- reset state
      tick(); tick();
      check("rst_cyc",     {31'b0, bus.wbm_cyc_o},   32'd0);
      check("rst_stb",     {31'b0, bus.wbm_stb_o},   32'd0);
      check("rst_we",      {31'b0, bus.wbm_we_o},    32'd0);
      check("rst_adr",     bus.wbm_adr_o,            32'd0);
      check("rst_sel",     {28'b0, bus.wbm_sel_o},   32'd0);
      check("rst_rsp_v",   {31'b0, bus.rsp_valid},   32'd0);
      check("rst_rsp_dat", bus.rsp_dat,              32'd0);
      check("rst_busy",    {31'b0, busy},            32'd0);
      rst = 1'b0;
      tick();
      check("req_ready_after_rst", {31'b0, bus.req_ready}, 32'd1);

      // ---------------- read, ack on 2nd strobe cycle
      send(1'b0, 32'h3000_0004, 32'h0, 4'hF);
      check("rd_stb_c1",   {31'b0, bus.wbm_stb_o}, 32'd1);
      check("rd_cyc_c1",   {31'b0, bus.wbm_cyc_o}, 32'd1);
      check("rd_we",       {31'b0, bus.wbm_we_o},  32'd0);
      check("rd_adr",      bus.wbm_adr_o,          32'h3000_0004);
      check("rd_sel",      {28'b0, bus.wbm_sel_o}, 32'hF);
      check("rd_req_rdy",  {31'b0, bus.req_ready}, 32'd0);
      check("rd_busy",     {31'b0, busy},          32'd1);
      bus.wbm_dat_i = 32'h1111_1111;   // must not be sampled without ack
      tick();
      check("rd_stb_c2",   {31'b0, bus.wbm_stb_o}, 32'd1);
      bus.wbm_ack_i = 1'b1;
      bus.wbm_dat_i = 32'hDEAD_BEEF;
      tick();
      bus.wbm_ack_i = 1'b0;
      bus.wbm_dat_i = 32'h0;
      check("rd_stb_after_ack", {31'b0, bus.wbm_stb_o}, 32'd0);
      check("rd_rsp_valid",     {31'b0, bus.rsp_valid}, 32'd1);
      check("rd_rsp_dat",       bus.rsp_dat,            32'hDEAD_BEEF);
      check("rd_rsp_timeout",   {31'b0, bus.rsp_timeout}, 32'd0);
      consume();

      // ---------------- write, ack on 1st strobe cycle
      send(1'b1, 32'h3000_0000, 32'h1234_5678, 4'h3);
      check("wr_we",      {31'b0, bus.wbm_we_o},  32'd1);
      check("wr_adr",     bus.wbm_adr_o,          32'h3000_0000);
      check("wr_dat",     bus.wbm_dat_o,          32'h1234_5678);
      check("wr_sel",     {28'b0, bus.wbm_sel_o}, 32'h3);
      bus.wbm_ack_i = 1'b1;
      bus.wbm_dat_i = 32'hFFFF_FFFF;
      tick();
      bus.wbm_ack_i = 1'b0;
      check("wr_cyc_after_ack", {31'b0, bus.wbm_cyc_o}, 32'd0);
      check("wr_rsp_valid",     {31'b0, bus.rsp_valid}, 32'd1);
      check("wr_rsp_dat",       bus.rsp_dat,            32'd0);
      check("wr_rsp_timeout",   {31'b0, bus.rsp_timeout}, 32'd0);
      consume();

      // ---------------- timeout, no ack
      bus.wbm_dat_i = 32'h2222_2222;
      send(1'b0, 32'h3000_0008, 32'h0, 4'hF);
      n = 0;
      while (bus.wbm_stb_o && n < 40) begin
         n++;
         tick();
      end
      check("to_stb_cycles",  n,                        32'd16);
      check("to_rsp_valid",   {31'b0, bus.rsp_valid},   32'd1);
      check("to_rsp_timeout", {31'b0, bus.rsp_timeout}, 32'd1);
      check("to_rsp_dat",     bus.rsp_dat,              32'd0);
      consume();

      // ---------------- ack on the 16th (final) strobe cycle
      send(1'b0, 32'h3000_000C, 32'h0, 4'hF);
      for (int i = 0; i < 15; i++) tick();
      check("late_stb_c16", {31'b0, bus.wbm_stb_o}, 32'd1);
      bus.wbm_ack_i = 1'b1;
      bus.wbm_dat_i = 32'hA5A5_A5A5;
      tick();
      bus.wbm_ack_i = 1'b0;
      check("late_rsp_valid",   {31'b0, bus.rsp_valid},   32'd1);
      check("late_rsp_timeout", {31'b0, bus.rsp_timeout}, 32'd0);
      check("late_rsp_dat",     bus.rsp_dat,              32'hA5A5_A5A5);

      // ---------------- backpressure with stray ack and new request
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_adr   = 32'h4000_0000;
      bus.req_dat   = 32'h5555_5555;
      bus.req_sel   = 4'h1;
      bus.wbm_ack_i = 1'b1;
      bus.wbm_dat_i = 32'h5555_5555;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
         check("bp_rsp_dat",   bus.rsp_dat,            32'hA5A5_A5A5);
         check("bp_req_ready", {31'b0, bus.req_ready}, 32'd0);
         check("bp_stb",       {31'b0, bus.wbm_stb_o}, 32'd0);
      end
      check("bp_adr_kept", bus.wbm_adr_o,         32'h3000_000C);
      check("bp_we_kept",  {31'b0, bus.wbm_we_o}, 32'd0);
      bus.req_valid = 1'b0;
      bus.wbm_ack_i = 1'b0;
      consume();

      // ---------------- reset on the 3rd BUS cycle
      send(1'b0, 32'h3000_0010, 32'h0, 4'hF);
      tick(); tick();
      check("rb_stb_c3", {31'b0, bus.wbm_stb_o}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rb_cyc",       {31'b0, bus.wbm_cyc_o}, 32'd0);
      check("rb_stb",       {31'b0, bus.wbm_stb_o}, 32'd0);
      check("rb_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
      check("rb_busy",      {31'b0, busy},          32'd0);
      tick();
      check("rb_req_ready", {31'b0, bus.req_ready}, 32'd1);
      check("rb_no_rsp",    {31'b0, bus.rsp_valid}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
